// File: rtl/collatz_host_ctrl_pkg.sv
// Shared definitions for the Collatz tile host sequencer: state encoding,
// tile pin bit positions and helpers that build the uio_in control byte.
package collatz_host_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_GO         = 3'd2,
    ST_WAIT_ENTER = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_READ       = 3'd5,
    ST_DONE       = 3'd6
  } state_e;

  // uio_in / uio_out bit positions on the tile
  localparam int unsigned UIO_WE       = 7;
  localparam int unsigned UIO_GO       = 6;
  localparam int unsigned UIO_SEL      = 4;
  localparam int unsigned UIO_ADDR_MSB = 3;
  localparam int unsigned UIO_ADDR_LSB = 0;
  localparam int unsigned UIO_BUSY     = 7;

  // uio_oe patterns: compute phase drives bit 7, IO phase drives nothing
  localparam logic [7:0] OE_COMPUTE = 8'h80;
  localparam logic [7:0] OE_IO      = 8'h00;

  // Control byte for writing input byte k
  function automatic logic [7:0] write_uio(input logic [1:0] k);
    logic [7:0] v;
    v = 8'h00;
    v[UIO_WE] = 1'b1;
    v[UIO_ADDR_MSB:UIO_ADDR_LSB] = {2'b00, k};
    return v;
  endfunction

  // Control byte for the compute request pulse (write enable kept low)
  function automatic logic [7:0] go_uio();
    logic [7:0] v;
    v = 8'h00;
    v[UIO_GO] = 1'b1;
    return v;
  endfunction

  // Control byte for reading byte addr of orbit (sel=0) or record (sel=1)
  function automatic logic [7:0] read_uio(input logic sel, input logic [1:0] addr);
    logic [7:0] v;
    v = 8'h00;
    v[UIO_SEL] = sel;
    v[UIO_ADDR_MSB:UIO_ADDR_LSB] = {2'b00, addr};
    return v;
  endfunction

endpackage

// File: rtl/collatz_host_ctrl_if.sv
// Bundle of host-side request/result signals and tile pin signals.
// slave: the sequencer; master: the host plus the tile it talks to.
interface collatz_host_ctrl_if;
  logic        start;
  logic [31:0] number;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] orbit_len;
  logic [31:0] path_record;
  logic [7:0]  dev_ui;
  logic [7:0]  dev_uio;
  logic [7:0]  dev_uo;
  logic [7:0]  dev_uio_out;
  logic [7:0]  dev_uio_oe;

  modport master (
    output start, number, dev_uo, dev_uio_out, dev_uio_oe,
    input  busy, done, timeout, orbit_len, path_record, dev_ui, dev_uio
  );

  modport slave (
    input  start, number, dev_uo, dev_uio_out, dev_uio_oe,
    output busy, done, timeout, orbit_len, path_record, dev_ui, dev_uio
  );
endinterface

// File: rtl/collatz_watchdog.sv
// Loadable down-counter guarding the wait states; expired once it hits zero.
module collatz_watchdog #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Count down while enabled; load/clear take priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1);
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/collatz_host_ctrl.sv
// Host sequencer for the Collatz tile: writes a 32-bit start value,
// pulses go, follows the tile's compute phase via uio_oe[7], then reads
// orbit length and path record back byte by byte.
module collatz_host_ctrl
  import collatz_host_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned BITS           = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  collatz_host_ctrl_if.slave bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // GO cycle itself counts as the first watched cycle
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  state_e           state_r, state_nx;
  logic [3:0]       cnt_r, cnt_nx;        // write byte k, or read {j, phase}
  logic [BITS-1:0]  number_r, number_nx;
  logic             timeout_r, timeout_nx;
  logic             busy_r, done_r;
  logic [31:0]      orbit_r, path_r;
  logic [7:0]       dev_ui_r, dev_uio_r, dev_ui_nx, dev_uio_nx;
  logic             capture_s;
  logic             in_compute_s;
  logic             wd_clear_s, wd_load_s, wd_en_s, wd_expired_s;
  logic             unused_s;

  assign in_compute_s = ((bus.dev_uio_oe & OE_COMPUTE) != OE_IO);
  assign unused_s     = ^{bus.dev_uio_out, bus.dev_uio_oe[6:0]};

  collatz_watchdog #(.WIDTH(WD_W)) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (wd_clear_s),
    .load       (wd_load_s),
    .load_value (WD_LOAD),
    .en         (wd_en_s),
    .expired    (wd_expired_s)
  );

  // Next-state, counter and watchdog control
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    number_nx  = number_r;
    timeout_nx = timeout_r;
    capture_s  = 1'b0;
    wd_clear_s = 1'b0;
    wd_load_s  = 1'b0;
    wd_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          number_nx  = bus.number;
          timeout_nx = 1'b0;
          cnt_nx     = 4'd0;
          wd_clear_s = 1'b1;
          state_nx   = ST_WRITE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_r == 4'd3) begin
          cnt_nx    = 4'd0;
          wd_load_s = 1'b1;
          state_nx  = ST_GO;
        end else begin
          cnt_nx = cnt_r + 4'd1;
        end
      end
      ST_GO: begin
        wd_en_s  = 1'b1;
        state_nx = ST_WAIT_ENTER;
      end
      ST_WAIT_ENTER: begin
        wd_en_s = 1'b1;
        if (wd_expired_s) begin
          timeout_nx = 1'b1;
          state_nx   = ST_DONE;
        end else if (in_compute_s) begin
          state_nx = ST_WAIT_DONE;
        end else begin
          state_nx = ST_WAIT_ENTER;
        end
      end
      ST_WAIT_DONE: begin
        wd_en_s = 1'b1;
        if (wd_expired_s) begin
          timeout_nx = 1'b1;
          state_nx   = ST_DONE;
        end else if (!in_compute_s) begin
          cnt_nx   = 4'd0;
          state_nx = ST_READ;
        end else begin
          state_nx = ST_WAIT_DONE;
        end
      end
      ST_READ: begin
        capture_s = cnt_r[0];
        if (cnt_r == 4'd15) begin
          state_nx = ST_DONE;
        end else begin
          cnt_nx = cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Pin values for the coming cycle, derived from where the FSM is going
  always_comb begin
    dev_ui_nx  = 8'h00;
    dev_uio_nx = 8'h00;
    case (state_nx)
      ST_WRITE: begin
        dev_uio_nx = write_uio(cnt_nx[1:0]);
        dev_ui_nx  = number_nx[{cnt_nx[1:0], 3'b000} +: 8];
      end
      ST_GO: begin
        dev_uio_nx = go_uio();
      end
      ST_READ: begin
        dev_uio_nx = read_uio(cnt_nx[3], cnt_nx[2:1]);
      end
      default: begin
        dev_uio_nx = 8'h00;
      end
    endcase
  end

  // State, pins, status and captured results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      number_r  <= {BITS{1'b0}};
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      orbit_r   <= 32'd0;
      path_r    <= 32'd0;
      dev_ui_r  <= 8'h00;
      dev_uio_r <= 8'h00;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      number_r  <= number_nx;
      timeout_r <= timeout_nx;
      busy_r    <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      done_r    <= (state_nx == ST_DONE);
      dev_ui_r  <= dev_ui_nx;
      dev_uio_r <= dev_uio_nx;
      if (capture_s) begin
        if (cnt_r[3]) begin
          path_r[{cnt_r[2:1], 3'b000} +: 8] <= bus.dev_uo;
        end else begin
          orbit_r[{cnt_r[2:1], 3'b000} +: 8] <= bus.dev_uo;
        end
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timeout     = timeout_r;
  assign bus.orbit_len   = orbit_r;
  assign bus.path_record = path_r;
  assign bus.dev_ui      = dev_ui_r;
  assign bus.dev_uio     = dev_uio_r;

endmodule

// File: tb/tb_collatz_host_ctrl.sv
// Self-checking bench: a behavioural Collatz tile drives the device pins,
// expected results come from plain Collatz arithmetic.
module tb_collatz_host_ctrl;

  localparam int TO = 64;

  logic clk;
  logic rst_n;
  logic tile_rst_n;
  int   n_checks;
  int   n_errors;
  int   acc_orbit;
  logic [31:0] exp_orbit;
  logic [31:0] exp_path;

  collatz_host_ctrl_if bus();

  collatz_host_ctrl #(.TIMEOUT_CYCLES(TO), .BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Orbit length (steps to reach 1, at least one step) and peak value; -1 if it never ends
  function automatic int collatz_ref(input logic [31:0] n, output logic [31:0] rec);
    logic [31:0] x;
    int steps;
    rec = n;
    if (n == 32'd0) return -1;
    x = n;
    steps = 0;
    do begin
      x = x[0] ? (x * 32'd3 + 32'd1) : (x >> 1);
      steps++;
      if (x > rec) rec = x;
    end while (x != 32'd1 && steps < 1000);
    if (x != 32'd1) return -1;
    return steps;
  endfunction

  // ---------------- behavioural tile ----------------
  logic [31:0] t_num, t_orbit, t_rec, go_rec;
  int          t_left, go_steps;
  bit          t_stuck;

  always_comb go_steps = collatz_ref(t_num, go_rec);

  always @(posedge clk or negedge tile_rst_n) begin
    if (!tile_rst_n) begin
      t_num <= 32'd0; t_orbit <= 32'd0; t_rec <= 32'd0; t_left <= 0; t_stuck <= 1'b0;
    end else begin
      if (bus.dev_uio[7]) t_num[{bus.dev_uio[1:0], 3'b000} +: 8] <= bus.dev_ui;
      if (bus.dev_uio[6] && t_left == 0 && !t_stuck) begin
        if (go_steps < 0) t_stuck <= 1'b1;
        else begin
          t_left  <= go_steps;
          t_orbit <= t_orbit + 32'(go_steps);
          t_rec   <= go_rec;
        end
      end else if (t_left > 0) begin
        t_left <= t_left - 1;
      end
    end
  end

  assign bus.dev_uio_oe  = (t_left > 0 || t_stuck) ? 8'h80 : 8'h00;
  assign bus.dev_uio_out = bus.dev_uio_oe;
  assign bus.dev_uo = bus.dev_uio[4] ? t_rec[{bus.dev_uio[1:0], 3'b000} +: 8]
                                     : t_orbit[{bus.dev_uio[1:0], 3'b000} +: 8];

  // Write enable and go must never be driven together
  always @(negedge clk) begin
    if (rst_n) check("we_go_excl", {31'd0, bus.dev_uio[7] & bus.dev_uio[6]}, 32'd0);
  end

  task automatic tile_reset();
    @(negedge clk); tile_rst_n = 1'b0;
    @(negedge clk); tile_rst_n = 1'b1;
    acc_orbit = 0;
  endtask

  task automatic run_case(input logic [31:0] n, input bit poke);
    logic [31:0] rec;
    int steps, cyc, go_cyc, we_cnt, go_cnt, oe_cnt;
    bit seen, poked, exp_to;
    steps = collatz_ref(n, rec);
    exp_to = (steps < 0);
    cyc = 0; go_cyc = 0; go_cnt = 0; oe_cnt = 0; seen = 1'b0; poked = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.number = n;
    @(negedge clk); bus.start = 1'b0; bus.number = $urandom;
    check("accept_busy", {31'd0, bus.busy}, 32'd1);
    check("accept_to_clr", {31'd0, bus.timeout}, 32'd0);
    check("first_uio", {24'd0, bus.dev_uio}, 32'h80);
    check("first_ui", {24'd0, bus.dev_ui}, {24'd0, n[7:0]});
    we_cnt = 1;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.dev_uio[7]) we_cnt++;
      if (bus.dev_uio == 8'h40) begin go_cnt++; go_cyc = cyc; end
      if (bus.dev_uio_oe[7]) oe_cnt++;
      if (poke && oe_cnt == 3 && !poked) begin
        bus.start = 1'b1; bus.number = 32'd5; poked = 1'b1;
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("we_cycles", 32'(we_cnt), 32'd4);
      check("go_cycles", 32'(go_cnt), 32'd1);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("timeout", {31'd0, bus.timeout}, {31'd0, exp_to});
      if (exp_to) begin
        check("to_lat_hi", {31'd0, (cyc - go_cyc) <= TO}, 32'd1);
        check("to_lat_lo", {31'd0, (cyc - go_cyc) >= TO - 4}, 32'd1);
      end else begin
        acc_orbit += steps;
        exp_orbit = 32'(acc_orbit);
        exp_path  = rec;
        check("run_lat", {31'd0, (cyc + 1 >= steps + 20) && (cyc + 1 <= steps + 28)}, 32'd1);
      end
      check("orbit_len", bus.orbit_len, exp_orbit);
      check("path_record", bus.path_record, exp_path);
      @(negedge clk);
      check("done_pulse", {31'd0, bus.done}, 32'd0);
      check("orbit_held", bus.orbit_len, exp_orbit);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_to"}, {31'd0, bus.timeout}, 32'd0);
    check({tag, "_orbit"}, bus.orbit_len, 32'd0);
    check({tag, "_path"}, bus.path_record, 32'd0);
    check({tag, "_ui"}, {24'd0, bus.dev_ui}, 32'd0);
    check({tag, "_uio"}, {24'd0, bus.dev_uio}, 32'd0);
  endtask

  // Hard stop if the stimulus ever stalls
  initial begin
    #500000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] n, r;
    bit found;
    n_checks = 0; n_errors = 0; acc_orbit = 0;
    exp_orbit = 32'd0; exp_path = 32'd0;
    rst_n = 1'b0; tile_rst_n = 1'b0;
    bus.start = 1'b0; bus.number = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1; tile_rst_n = 1'b1;

    run_case(32'd3, 1'b0);                 // 7 / 16
    tile_reset();
    run_case(32'd1, 1'b0);                 // 3 / 4
    run_case(32'd3, 1'b0);                 // 10 / 16 accumulated
    tile_reset();
    run_case(32'd2, 1'b0);                 // one-cycle compute: 1 / 2
    tile_reset();
    run_case(32'd9, 1'b1);                 // start during wait is ignored
    tile_reset();
    run_case(32'd0, 1'b0);                 // never finishes: timeout, results held
    tile_reset();

    for (int i = 0; i < 10; i++) begin
      do n = 32'($urandom_range(1, 300)); while (collatz_ref(n, r) > 50);
      if ($urandom_range(0, 2) == 0) tile_reset();
      run_case(n, 1'b0);
    end

    // Reset in the middle of the read phase
    tile_reset();
    @(negedge clk); bus.start = 1'b1; bus.number = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (bus.dev_uio[4]) found = 1'b1;
    end
    check("reach_read", {31'd0, found}, 32'd1);
    acc_orbit += collatz_ref(32'd7, r);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    exp_orbit = 32'd0; exp_path = 32'd0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_case(32'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/collatz_host_ctrl.md
# collatz_host_ctrl

Host-side sequencer for the Collatz compute tile's byte-wide I/O protocol. It accepts a 32-bit start value from on-chip logic and performs a full run:

- writes the start value into the tile in four byte writes;
- pulses the compute request;
- tracks the tile's compute/IO phase through its output-enable pattern;
- reads back orbit length and path record as eight byte reads.

It sits between a test or host controller and the tile's ui/uo/uio pins.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65536 — maximum cycles spent in either wait state before the run is aborted.
- BITS, 32 — word width; fixed at 32, giving 4 bytes per word.

Ports. One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a run; sampled only in IDLE
- number  in  32  start value, captured when start is accepted
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse; results valid
- timeout  out  1  set with done when a wait expired; cleared on next accept
- orbit_len  out  32  captured orbit length; held until next accept
- path_record  out  32  captured path record; held until next accept
- dev_ui  out  8  drives tile ui_in (write data)
- dev_uio  out  8  drives tile uio_in: [7] write enable, [6] go, [4] read select (0 orbit, 1 record), [3:0] byte address
- dev_uo  in  8  tile uo_out (read data)
- dev_uio_out  in  8  tile uio_out; bit 7 is busy
- dev_uio_oe  in  8  tile uio_oe; bit 7 = 1 means the tile is in compute

## Operation
- States: IDLE, WRITE, GO, WAIT_ENTER, WAIT_DONE, READ, DONE.
- **IDLE**
  - If start=1: capture number, clear timeout, set busy, move to WRITE with byte index 0.
  - A start arriving in any other state is ignored.
- **WRITE**
  - One cycle per byte, k = 0..3.
  - Drive dev_uio = {1, 0, 0, 0, k[3:0]} and dev_ui = number[8k+:8].
  - After k=3, move to GO.
- **GO**
  - One cycle with dev_uio = 8'h40: go=1, write enable=0.
  - Then move to WAIT_ENTER with dev_uio = 0.
- **WAIT_ENTER**
  - Wait for dev_uio_oe[7]=1, then move to WAIT_DONE.
  - A compute phase lasting exactly one cycle must be caught: the oe bit is sampled every cycle, with no filtering.
- **WAIT_DONE**
  - Wait for dev_uio_oe[7]=0, then move to READ.
- **READ**
  - Eight reads, j = 0..7: sel = j[2], addr = j[1:0].
  - Each read holds dev_uio = {0, 0, 0, sel, 0, 0, addr} for 2 cycles.
  - dev_uo is captured on the 2nd cycle into orbit_len byte (sel=0) or path_record byte (sel=1).
  - After j=7, move to DONE.
- **DONE**
  - Pulse done for one cycle, clear busy, return to IDLE.
- **Timeout**
  - A watchdog counts cycles in WAIT_ENTER + WAIT_DONE combined, restarting at GO.
  - When the count reaches TIMEOUT_CYCLES: set timeout, skip READ, go to DONE.
  - orbit_len and path_record hold their previous values.
  - The tile stays in compute after a timeout; only the tile's own reset recovers it. The block does not retry.
- The block does not interpret the tile's results. Values are reported raw, including the tile's orbit_len accumulation across runs.

## Timing
- All outputs are registered.
- Reset values: state IDLE; busy, done, timeout = 0; orbit_len, path_record = 0; dev_ui = 0; dev_uio = 0.
- Asserting rst_n low mid-run returns to IDLE immediately with the reset values above.
- Accept → first write byte on the pins: 1 cycle.
- Write and GO phases: 5 cycles. Read phase: 16 cycles.
- Minimum run, accept to done, with a 1-cycle compute: about 25 cycles.
- dev_uio never has bits 7 and 6 both set.

## Structure
- Shared package holds:
  - state enum;
  - pin bit positions: WE=7, GO=6, SEL=4, ADDR=[3:0], BUSY=7;
  - OE_COMPUTE = 8'h80, OE_IO = 8'h00.
- One sub-module: collatz_watchdog, a loadable down-counter with clear, load and expired outputs.

## Test plan
All scenarios run against the real tile, freshly reset unless stated.
- number=3 → done after tile exit; orbit_len=7, path_record=16, timeout=0.
- number=1, then number=3 back-to-back with no tile reset → first run 3/4; second run orbit_len=10, path_record=16.
- number=2 (1-cycle compute) → WAIT_ENTER catches the oe pulse; orbit_len=1, path_record=2.
- number=0 with TIMEOUT_CYCLES=64 → done and timeout=1 within 64 cycles of GO; results unchanged.
- start pulsed during WAIT_DONE → ignored; number not recaptured.
- rst_n dropped during READ → outputs at reset values the same cycle; a new start then completes correctly.
